// File: rtl/signal_select_pkg.sv
// rtl/signal_select_pkg.sv - register map, selector codes and commit FSM states for signal_select_csr
package signal_select_pkg;

  localparam logic [2:0] ADDR_SIG_SH = 3'd0;
  localparam logic [2:0] ADDR_MOD_SH = 3'd1;
  localparam logic [2:0] ADDR_INC_SH = 3'd2;
  localparam logic [2:0] ADDR_CTRL   = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;
  localparam logic [2:0] ADDR_LIVE   = 3'd5;
  localparam logic [2:0] ADDR_UPDCNT = 3'd6;
  localparam logic [2:0] ADDR_RSVD   = 3'd7;

  localparam int CTRL_COMMIT_BIT    = 0;
  localparam int CTRL_IMMED_BIT     = 1;
  localparam int STATUS_PENDING_BIT = 0;
  localparam int STATUS_ERR_BIT     = 1;

  typedef enum logic [7:0] {
    SIG_SIN = 8'd0,
    SIG_COS = 8'd1,
    SIG_SAW = 8'd2,
    SIG_SQU = 8'd3
  } sig_sel_e;

  typedef enum logic [3:0] {
    MOD_ASK  = 4'd0,
    MOD_FSK  = 4'd1,
    MOD_BPSK = 4'd2,
    MOD_LFSR = 4'd3
  } mod_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } csr_state_e;

endpackage

// File: rtl/signal_select_csr.sv
// rtl/signal_select_csr.sv - Avalon-MM CSR staging scope selectors, applied atomically on sample_tick
module signal_select_csr
  import signal_select_pkg::*;
#(
  parameter logic [31:0] DEFAULT_INC = 32'h102,
  parameter int unsigned NUM_SEL     = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        sample_tick,
  output logic [7:0]  signal_selector,
  output logic [3:0]  modulation_selector,
  output logic [31:0] dds_increment,
  output logic        update_pulse
);

  csr_state_e  r_state, w_state_nxt;
  logic [7:0]  r_sig_sh, r_sig;
  logic [3:0]  r_mod_sh, r_mod;
  logic [31:0] r_inc_sh, r_inc;
  logic [15:0] r_updcnt;
  logic        r_err, r_update_pulse;
  logic [31:0] r_readdata, w_rd_mux, w_status;
  logic        w_wr_sig, w_wr_mod, w_wr_inc, w_wr_status;
  logic        w_commit, w_immed, w_apply, w_sig_legal, w_mod_legal;

  assign w_wr_sig    = avs_write && (avs_address == ADDR_SIG_SH);
  assign w_wr_mod    = avs_write && (avs_address == ADDR_MOD_SH);
  assign w_wr_inc    = avs_write && (avs_address == ADDR_INC_SH);
  assign w_wr_status = avs_write && (avs_address == ADDR_STATUS);
  assign w_commit    = avs_write && (avs_address == ADDR_CTRL) && avs_writedata[CTRL_COMMIT_BIT];
  assign w_immed     = w_commit && avs_writedata[CTRL_IMMED_BIT];
  assign w_sig_legal = 32'(avs_writedata[7:0]) < NUM_SEL;
  assign w_mod_legal = 32'(avs_writedata[3:0]) < NUM_SEL;

  // A tick only applies once PEND is registered, so a tick in the COMMIT cycle is ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_apply     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_immed) begin
          w_apply = 1'b1;
        end else if (w_commit) begin
          w_state_nxt = PEND;
        end
      end
      PEND: begin
        if (w_immed || sample_tick) begin
          w_apply     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_status                     = '0;
    w_status[STATUS_PENDING_BIT] = (r_state == PEND);
    w_status[STATUS_ERR_BIT]     = r_err;
    case (avs_address)
      ADDR_SIG_SH: w_rd_mux = {24'b0, r_sig_sh};
      ADDR_MOD_SH: w_rd_mux = {28'b0, r_mod_sh};
      ADDR_INC_SH: w_rd_mux = r_inc_sh;
      ADDR_STATUS: w_rd_mux = w_status;
      ADDR_LIVE:   w_rd_mux = {r_inc[15:0], r_mod, 4'b0, r_sig};
      ADDR_UPDCNT: w_rd_mux = {16'b0, r_updcnt};
      default:     w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_sig_sh       <= '0;
      r_mod_sh       <= '0;
      r_inc_sh       <= DEFAULT_INC;
      r_sig          <= '0;
      r_mod          <= '0;
      r_inc          <= DEFAULT_INC;
      r_updcnt       <= '0;
      r_err          <= 1'b0;
      r_update_pulse <= 1'b0;
      r_readdata     <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_update_pulse <= w_apply;
      if (avs_read) r_readdata <= w_rd_mux;
      // Live takes the pre-write shadow; a shadow write in this cycle stays staged.
      if (w_apply) begin
        r_sig    <= r_sig_sh;
        r_mod    <= r_mod_sh;
        r_inc    <= r_inc_sh;
        r_updcnt <= r_updcnt + 16'd1;
      end
      if (w_wr_sig && w_sig_legal) r_sig_sh <= avs_writedata[7:0];
      if (w_wr_mod && w_mod_legal) r_mod_sh <= avs_writedata[3:0];
      if (w_wr_inc) r_inc_sh <= avs_writedata;
      if ((w_wr_sig && !w_sig_legal) || (w_wr_mod && !w_mod_legal)) begin
        r_err <= 1'b1;
      end else if (w_wr_status && avs_writedata[STATUS_ERR_BIT]) begin
        r_err <= 1'b0;
      end
    end
  end

  assign avs_readdata        = r_readdata;
  assign signal_selector     = r_sig;
  assign modulation_selector = r_mod;
  assign dds_increment       = r_inc;
  assign update_pulse        = r_update_pulse;

endmodule

// File: tb/tb_signal_select_csr.sv
// tb/tb_signal_select_csr.sv - randomized self-checking bench for signal_select_csr
module tb_signal_select_csr;
  import signal_select_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  avs_address = '0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic        sample_tick = 1'b0;
  logic [7:0]  signal_selector;
  logic [3:0]  modulation_selector;
  logic [31:0] dds_increment;
  logic        update_pulse;

  int checks = 0;
  int errors = 0;

  logic [7:0]  m_sig_sh, m_sig;
  logic [3:0]  m_mod_sh, m_mod;
  logic [31:0] m_inc_sh, m_inc, m_rd;
  logic [15:0] m_cnt;
  logic        m_pend, m_err, m_pulse;

  always #5 clk = ~clk;

  signal_select_csr dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .avs_address         (avs_address),
    .avs_write           (avs_write),
    .avs_writedata       (avs_writedata),
    .avs_read            (avs_read),
    .avs_readdata        (avs_readdata),
    .sample_tick         (sample_tick),
    .signal_selector     (signal_selector),
    .modulation_selector (modulation_selector),
    .dds_increment       (dds_increment),
    .update_pulse        (update_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_sig_sh = 8'd0; m_sig = 8'd0;
    m_mod_sh = 4'd0; m_mod = 4'd0;
    m_inc_sh = 32'h102; m_inc = 32'h102;
    m_cnt = 16'd0; m_pend = 1'b0; m_err = 1'b0; m_pulse = 1'b0; m_rd = 32'd0;
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return {24'b0, m_sig_sh};
      3'd1:    return {28'b0, m_mod_sh};
      3'd2:    return m_inc_sh;
      3'd4:    return {30'b0, m_err, m_pend};
      3'd5:    return {m_inc[15:0], m_mod, 4'b0, m_sig};
      3'd6:    return {16'b0, m_cnt};
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".sig"},   signal_selector, m_sig);
    chk({tag, ".mod"},   modulation_selector, m_mod);
    chk({tag, ".inc"},   dds_increment, m_inc);
    chk({tag, ".pulse"}, update_pulse, m_pulse);
    chk({tag, ".rd"},    avs_readdata, m_rd);
  endtask

  // One bus cycle: drive at negedge, advance the model, check at the next negedge.
  task automatic cycle(input logic [2:0] a, input logic wr, input logic [31:0] wd,
                       input logic rd, input logic tk);
    logic apply, commit;
    avs_address = a; avs_write = wr; avs_writedata = wd; avs_read = rd; sample_tick = tk;
    if (rd) m_rd = m_read(a);
    commit = wr && (a == 3'd3) && wd[0];
    apply  = (m_pend && tk) || (commit && wd[1]);
    m_pulse = apply;
    if (apply) begin
      m_sig = m_sig_sh; m_mod = m_mod_sh; m_inc = m_inc_sh;
      m_cnt = m_cnt + 16'd1;
      m_pend = 1'b0;
    end else if (commit) begin
      m_pend = 1'b1;
    end
    if (wr) begin
      case (a)
        3'd0: if (wd[7:0] < 8'd4) m_sig_sh = wd[7:0]; else m_err = 1'b1;
        3'd1: if (wd[3:0] < 4'd4) m_mod_sh = wd[3:0]; else m_err = 1'b1;
        3'd2: m_inc_sh = wd;
        3'd4: if (wd[1]) m_err = 1'b0;
        default: ;
      endcase
    end
    @(negedge clk);
    avs_write = 1'b0; avs_read = 1'b0; sample_tick = 1'b0;
    check_outputs("cyc");
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    m_reset();
    #1 check_outputs("arst");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [2:0]  a;
    logic [31:0] wd;
    m_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check_outputs("rst");
    chk("rst.inc_const", dds_increment, 32'h102);
    cycle(ADDR_STATUS, 1'b0, 0, 1'b1, 1'b0);
    chk("rst.status", avs_readdata, 32'd0);
    cycle(ADDR_UPDCNT, 1'b0, 0, 1'b1, 1'b0);
    chk("rst.updcnt", avs_readdata, 32'd0);

    cycle(ADDR_SIG_SH, 1'b1, 32'(SIG_SAW), 1'b0, 1'b0);
    cycle(ADDR_MOD_SH, 1'b1, 32'(MOD_FSK), 1'b0, 1'b0);
    cycle(ADDR_INC_SH, 1'b1, 32'h400, 1'b0, 1'b0);
    cycle(ADDR_CTRL, 1'b1, 32'h1, 1'b0, 1'b0);
    repeat (4) begin
      cycle(ADDR_RSVD, 1'b0, 0, 1'b0, 1'b0);
      chk("stage.hold", signal_selector, 32'd0);
    end
    cycle(ADDR_RSVD, 1'b0, 0, 1'b0, 1'b1);
    chk("stage.sig", signal_selector, 32'd2);
    chk("stage.mod", modulation_selector, 32'd1);
    chk("stage.inc", dds_increment, 32'h400);
    chk("stage.pulse", update_pulse, 32'd1);
    cycle(ADDR_UPDCNT, 1'b0, 0, 1'b1, 1'b0);
    chk("stage.pulse_off", update_pulse, 32'd0);
    chk("stage.updcnt", avs_readdata, 32'd1);

    cycle(ADDR_SIG_SH, 1'b1, 32'd3, 1'b0, 1'b0);
    cycle(ADDR_CTRL, 1'b1, 32'h1, 1'b0, 1'b1);
    chk("cotick.nochange", signal_selector, 32'd2);
    cycle(ADDR_RSVD, 1'b0, 0, 1'b0, 1'b1);
    chk("cotick.next", signal_selector, 32'd3);

    cycle(ADDR_MOD_SH, 1'b1, 32'd7, 1'b0, 1'b0);
    cycle(ADDR_MOD_SH, 1'b0, 0, 1'b1, 1'b0);
    chk("err.mod_kept", avs_readdata, 32'd1);
    cycle(ADDR_STATUS, 1'b0, 0, 1'b1, 1'b0);
    chk("err.status", avs_readdata, 32'h2);
    cycle(ADDR_STATUS, 1'b1, 32'h2, 1'b0, 1'b0);
    cycle(ADDR_STATUS, 1'b0, 0, 1'b1, 1'b0);
    chk("err.cleared", avs_readdata, 32'h0);

    cycle(ADDR_SIG_SH, 1'b1, 32'd1, 1'b0, 1'b0);
    cycle(ADDR_CTRL, 1'b1, 32'h3, 1'b0, 1'b0);
    chk("immed.sig", signal_selector, 32'd1);
    chk("immed.pulse", update_pulse, 32'd1);

    cycle(ADDR_SIG_SH, 1'b1, 32'd0, 1'b1, 1'b0);
    chk("rdwr.prewrite", avs_readdata, 32'd1);

    repeat (2000) begin
      a = 3'($urandom_range(0, 7));
      case (a)
        3'd0, 3'd1: wd = $urandom_range(0, 6);
        3'd3:       wd = $urandom_range(0, 3);
        default:    wd = $urandom;
      endcase
      cycle(a, 1'($urandom_range(0, 1)), wd, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0));
    end

    cycle(ADDR_SIG_SH, 1'b1, 32'd2, 1'b0, 1'b0);
    cycle(ADDR_CTRL, 1'b1, 32'h1, 1'b0, 1'b0);
    do_reset();
    cycle(ADDR_STATUS, 1'b0, 0, 1'b1, 1'b0);
    chk("rstpend.status", avs_readdata, 32'd0);
    repeat (3) cycle(ADDR_RSVD, 1'b0, 0, 1'b0, 1'b1);
    chk("rstpend.sig", signal_selector, 32'd0);
    chk("rstpend.pulse", update_pulse, 32'd0);

    do_reset();
    repeat (65535) cycle(ADDR_CTRL, 1'b1, 32'h3, 1'b0, 1'b0);
    cycle(ADDR_UPDCNT, 1'b0, 0, 1'b1, 1'b0);
    chk("wrap.ffff", avs_readdata, 32'hFFFF);
    cycle(ADDR_CTRL, 1'b1, 32'h3, 1'b0, 1'b0);
    cycle(ADDR_UPDCNT, 1'b0, 0, 1'b1, 1'b0);
    chk("wrap.zero", avs_readdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
